// File: rtl/product_accumulator.sv
// product_accumulator
// Accumulates COUNT unsigned 8-bit products per frame and presents the
// frame sum with a sticky overflow flag, using a valid/ready handshake on
// both sides.
// Optional build macro PRODUCT_ACCUMULATOR_SATURATE_EN: when defined, the
// accumulator clamps to all-ones on carry-out instead of wrapping.
module product_accumulator #(
  parameter int ACC_W = 12,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [7:0]       prod,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(COUNT - 1);

  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] acc;
  logic [7:0]       cnt;
  logic             ovf_pend;
  logic             accept;
  logic             last_accept;
  logic [ACC_W:0]   add_full;
  logic             carry;
  logic [ACC_W-1:0] add_res;

  // Handshake outputs follow the state directly, so an asynchronous reset
  // shows up on in_ready/out_valid without waiting for a clock edge.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

  // A clear in the same cycle as a valid product wins and discards it.
  assign accept      = in_valid && in_ready && !clr;
  assign last_accept = accept && (cnt == LAST_CNT);

  assign add_full = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, prod};
  assign carry    = add_full[ACC_W];

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  // Once clamped at all-ones, any further non-zero product carries again,
  // so the accumulator stays pinned for the rest of the frame.
  assign add_res = carry ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
`else
  assign add_res = add_full[ACC_W-1:0];
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: leave ACCUM on the last product, leave HOLD on
  // downstream acceptance or on a clear that drops the result.
  always_comb begin
    state_next = state;
    case (state)
      ACCUM: if (last_accept) state_next = HOLD;
      HOLD:  if (clr || out_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Accumulator datapath: sum and ovf are only written when a frame
  // completes, so they stay stable for the whole HOLD period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      sum      <= '0;
      ovf      <= 1'b0;
    end else if (state == ACCUM) begin
      if (clr) begin
        acc      <= '0;
        cnt      <= '0;
        ovf_pend <= 1'b0;
      end else if (last_accept) begin
        sum      <= add_res;
        ovf      <= ovf_pend | carry;
        acc      <= '0;
        cnt      <= '0;
        ovf_pend <= 1'b0;
      end else if (accept) begin
        acc      <= add_res;
        cnt      <= cnt + 8'd1;
        ovf_pend <= ovf_pend | carry;
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator
// Drives three instances (default, ACC_W=8, COUNT=1) and compares their
// outputs against a frame-level arithmetic model of the accumulator.
// Honours PRODUCT_ACCUMULATOR_SATURATE_EN when computing expected sums.
module tb_product_accumulator;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Instance a: default parameters
  logic        a_clr, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf;
  logic [7:0]  a_prod;
  logic [11:0] a_sum;

  // Instance b: 8-bit accumulator
  logic        b_clr, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf;
  logic [7:0]  b_prod;
  logic [7:0]  b_sum;

  // Instance c: one product per frame
  logic        c_clr, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_ovf;
  logic [7:0]  c_prod;
  logic [11:0] c_sum;

  product_accumulator #(.ACC_W(12), .COUNT(4)) dut_a (
    .clk(clk), .rst(rst), .clr(a_clr), .prod(a_prod), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .sum(a_sum), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .ovf(a_ovf)
  );

  product_accumulator #(.ACC_W(8), .COUNT(4)) dut_b (
    .clk(clk), .rst(rst), .clr(b_clr), .prod(b_prod), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .sum(b_sum), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .ovf(b_ovf)
  );

  product_accumulator #(.ACC_W(12), .COUNT(1)) dut_c (
    .clk(clk), .rst(rst), .clr(c_clr), .prod(c_prod), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .sum(c_sum), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .ovf(c_ovf)
  );

  int checks = 0;
  int passed = 0;
  int frame_q[$];
  longint exp_sum;
  bit exp_ovf;

  // Reference: running integer sum of the frame, wrapped or clamped at 2^w.
  function automatic void model_frame(input int w, output longint s, output bit o);
    longint lim;
    longint run;
    lim = longint'(1) << w;
    run = 0;
    o = 1'b0;
    foreach (frame_q[i]) begin
      run = run + longint'(frame_q[i]);
      if (run >= lim) begin
        o = 1'b1;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
        run = lim - 1;
`else
        run = run - lim;
`endif
      end
    end
    s = run;
  endfunction

  function automatic void random_frame(input int n);
    frame_q = {};
    for (int i = 0; i < n; i++) frame_q.push_back(int'($urandom_range(0, 255)));
  endfunction

  // Present frame_q to instance a one product per cycle.
  task automatic a_send;
    foreach (frame_q[i]) begin
      a_in_valid = 1'b1;
      a_prod = 8'(frame_q[i]);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
  endtask

  task automatic b_send;
    foreach (frame_q[i]) begin
      b_in_valid = 1'b1;
      b_prod = 8'(frame_q[i]);
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    {a_clr, a_in_valid, a_prod, a_out_ready} = '0;
    {b_clr, b_in_valid, b_prod, b_out_ready} = '0;
    {c_clr, c_in_valid, c_prod, c_out_ready} = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) $display("[TB] FAIL reset_handshake in_ready=%b out_valid=%b expected 1/0", a_in_ready, a_out_valid);
    else passed++;
    checks++;
    if (a_sum !== 12'd0 || a_ovf !== 1'b0) $display("[TB] FAIL reset_outputs sum=%0d ovf=%b expected 0/0", a_sum, a_ovf);
    else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    frame_q = '{15, 225, 1, 100};
    model_frame(12, exp_sum, exp_ovf);
    a_out_ready = 1'b1;
    foreach (frame_q[i]) begin
      a_in_valid = 1'b1;
      a_prod = 8'(frame_q[i]);
      if (i == 3) begin
        checks++;
        if (a_out_valid !== 1'b0) $display("[TB] FAIL basic_early_valid out_valid=%b expected 0", a_out_valid);
        else passed++;
      end
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) $display("[TB] FAIL basic_latency out_valid=%b in_ready=%b expected 1/0", a_out_valid, a_in_ready);
    else passed++;
    checks++;
    if (a_sum !== 12'(exp_sum) || a_ovf !== exp_ovf) $display("[TB] FAIL basic_sum sum=%0d ovf=%b expected %0d/%b", a_sum, a_ovf, exp_sum, exp_ovf);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) $display("[TB] FAIL basic_release out_valid=%b in_ready=%b expected 0/1", a_out_valid, a_in_ready);
    else passed++;
  endtask

  task automatic test_hold;
    random_frame(4);
    model_frame(12, exp_sum, exp_ovf);
    a_out_ready = 1'b0;
    a_send();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) $display("[TB] FAIL hold_handshake cycle=%0d out_valid=%b in_ready=%b expected 1/0", k, a_out_valid, a_in_ready);
      else passed++;
      checks++;
      if (a_sum !== 12'(exp_sum) || a_ovf !== exp_ovf) $display("[TB] FAIL hold_stable cycle=%0d sum=%0d ovf=%b expected %0d/%b", k, a_sum, a_ovf, exp_sum, exp_ovf);
      else passed++;
      a_in_valid = 1'b1;
      a_prod = 8'($urandom_range(1, 255));
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_out_valid !== 1'b0) $display("[TB] FAIL hold_release out_valid=%b expected 0", a_out_valid);
    else passed++;
    random_frame(4);
    model_frame(12, exp_sum, exp_ovf);
    a_send();
    checks++;
    if (a_sum !== 12'(exp_sum) || a_out_valid !== 1'b1) $display("[TB] FAIL hold_ignored_inputs sum=%0d out_valid=%b expected %0d/1", a_sum, a_out_valid, exp_sum);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap;
    b_out_ready = 1'b1;
    frame_q = '{200, 100, 0, 0};
    for (int f = 0; f < 7; f++) begin
      if (f > 0) random_frame(4);
      model_frame(8, exp_sum, exp_ovf);
      checks++;
      if (b_in_ready !== 1'b1) $display("[TB] FAIL wrap_ready frame=%0d in_ready=%b expected 1", f, b_in_ready);
      else passed++;
      b_send();
      checks++;
      if (b_out_valid !== 1'b1 || b_sum !== 8'(exp_sum) || b_ovf !== exp_ovf)
        $display("[TB] FAIL wrap_frame frame=%0d valid=%b sum=%0d ovf=%b expected 1/%0d/%b", f, b_out_valid, b_sum, b_ovf, exp_sum, exp_ovf);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_clear;
    a_out_ready = 1'b1;
    random_frame(2);
    a_send();
    a_clr = 1'b1;
    a_in_valid = 1'b1;
    a_prod = 8'($urandom_range(1, 255));
    @(posedge clk); #1;
    a_clr = 1'b0;
    a_in_valid = 1'b0;
    frame_q = '{1, 1, 1, 1};
    model_frame(12, exp_sum, exp_ovf);
    a_send();
    checks++;
    if (a_out_valid !== 1'b1 || a_sum !== 12'(exp_sum) || a_ovf !== exp_ovf)
      $display("[TB] FAIL clear_accum valid=%b sum=%0d ovf=%b expected 1/%0d/%b", a_out_valid, a_sum, a_ovf, exp_sum, exp_ovf);
    else passed++;
    @(posedge clk); #1;
    random_frame(4);
    a_out_ready = 1'b0;
    a_send();
    a_clr = 1'b1;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_clr = 1'b0;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) $display("[TB] FAIL clear_hold out_valid=%b in_ready=%b expected 0/1", a_out_valid, a_in_ready);
    else passed++;
    random_frame(4);
    model_frame(12, exp_sum, exp_ovf);
    a_send();
    checks++;
    if (a_sum !== 12'(exp_sum)) $display("[TB] FAIL clear_next_frame sum=%0d expected %0d", a_sum, exp_sum);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    a_out_ready = 1'b1;
    frame_q = '{77, 88, 99, 111};
    a_send();
    @(posedge clk); #1;
    random_frame(2);
    a_send();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) $display("[TB] FAIL async_reset_handshake in_ready=%b out_valid=%b expected 1/0", a_in_ready, a_out_valid);
    else passed++;
    checks++;
    if (a_sum !== 12'd0 || a_ovf !== 1'b0) $display("[TB] FAIL async_reset_outputs sum=%0d ovf=%b expected 0/0", a_sum, a_ovf);
    else passed++;
    #2;
    rst = 1'b0;
    frame_q = '{10, 10, 10, 10};
    model_frame(12, exp_sum, exp_ovf);
    a_send();
    checks++;
    if (a_out_valid !== 1'b1 || a_sum !== 12'(exp_sum)) $display("[TB] FAIL async_reset_next_frame valid=%b sum=%0d expected 1/%0d", a_out_valid, a_sum, exp_sum);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_count1;
    int p;
    c_out_ready = 1'b1;
    c_in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      p = int'($urandom_range(0, 255));
      frame_q = '{p};
      model_frame(12, exp_sum, exp_ovf);
      c_prod = 8'(p);
      checks++;
      if (c_in_ready !== 1'b1) $display("[TB] FAIL count1_ready k=%0d in_ready=%b expected 1", k, c_in_ready);
      else passed++;
      @(posedge clk); #1;
      checks++;
      if (c_out_valid !== 1'b1 || c_sum !== 12'(exp_sum) || c_ovf !== exp_ovf)
        $display("[TB] FAIL count1_frame k=%0d valid=%b sum=%0d ovf=%b expected 1/%0d/%b", k, c_out_valid, c_sum, c_ovf, exp_sum, exp_ovf);
      else passed++;
      c_prod = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    c_in_valid = 1'b0;
  endtask

  task automatic test_back_to_back;
    a_out_ready = 1'b1;
    for (int f = 0; f < 5; f++) begin
      random_frame(4);
      model_frame(12, exp_sum, exp_ovf);
      foreach (frame_q[i]) begin
        a_in_valid = 1'b1;
        a_prod = 8'(frame_q[i]);
        @(posedge clk); #1;
      end
      checks++;
      if (a_out_valid !== 1'b1 || a_sum !== 12'(exp_sum) || a_ovf !== exp_ovf)
        $display("[TB] FAIL b2b_frame f=%0d valid=%b sum=%0d ovf=%b expected 1/%0d/%b", f, a_out_valid, a_sum, a_ovf, exp_sum, exp_ovf);
      else passed++;
      a_prod = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      checks++;
      if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) $display("[TB] FAIL b2b_gap f=%0d in_ready=%b out_valid=%b expected 1/0", f, a_in_ready, a_out_valid);
      else passed++;
    end
    a_in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_wrap();
    test_clear();
    test_async_reset();
    test_count1();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
